alu_exec_unit: RTL and testbench

//  Execute-stage arithmetic block of the single-cycle MIPS CPU. Decodes the 6-bit ALU op from control

---
 rtl/alu_pkg.sv | 27 ++
 rtl/add32.sv | 12 +
 rtl/alu_exec_unit.sv | 119 +++++++++++
 tb/tb_alu_exec_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings: 4-bit ALU select codes and the 6-bit funct codes that
// control drives onto alu_op. The control unit imports the same package.
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_ADDU = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SUBU = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1010;
   localparam logic [3:0] ALU_SLTU = 4'b1011;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_XOR  = 4'b1101;

   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_ADDU = 6'b100001;
   localparam logic [5:0] FUNCT_SUB  = 6'b100010;
   localparam logic [5:0] FUNCT_SUBU = 6'b100011;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_XOR  = 6'b100110;
   localparam logic [5:0] FUNCT_NOR  = 6'b100111;
   localparam logic [5:0] FUNCT_SLT  = 6'b101010;
   localparam logic [5:0] FUNCT_SLTU = 6'b101011;

endpackage

// File: rtl/add32.sv
// Plain WIDTH-bit adder; the carry out is dropped so the sum wraps modulo 2^WIDTH.
module add32 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] sum_o
);

   assign sum_o = a_i + b_i;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage of the single-cycle MIPS CPU: ALU decode, ALU core, PC+4 and
// branch target adders, and a sticky signed-overflow flag.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       alu_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] imm32,
   output logic [3:0]       alu_ctl,
   output logic [WIDTH-1:0] alu_res,
   output logic             zero,
   output logic             ovf,
   output logic             cout,
   output logic             ovf_sticky,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] branch_tgt
);

   localparam int MSB = WIDTH - 1;

   logic [WIDTH:0]   sumAdd;
   logic [WIDTH:0]   sumSub;
   logic             ltSigned;
   logic             ltUnsigned;
   logic [WIDTH-1:0] immShifted;
   logic             ovfSticky_d;
   logic             ovfSticky_q;

   // Unknown funct codes fall back to ADD so lw/sw address generation works.
   always_comb begin
      alu_ctl = ALU_ADD;
      case (alu_op)
         FUNCT_ADD:  alu_ctl = ALU_ADD;
         FUNCT_ADDU: alu_ctl = ALU_ADDU;
         FUNCT_SUB:  alu_ctl = ALU_SUB;
         FUNCT_SUBU: alu_ctl = ALU_SUBU;
         FUNCT_AND:  alu_ctl = ALU_AND;
         FUNCT_OR:   alu_ctl = ALU_OR;
         FUNCT_XOR:  alu_ctl = ALU_XOR;
         FUNCT_NOR:  alu_ctl = ALU_NOR;
         FUNCT_SLT:  alu_ctl = ALU_SLT;
         FUNCT_SLTU: alu_ctl = ALU_SLTU;
         default:    alu_ctl = ALU_ADD;
      endcase
   end

   // Subtraction is a + ~b + 1, so cout=1 means no borrow; SLT uses a true
   // signed compare rather than the sign of a-b, which breaks on overflow.
   assign sumAdd     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   assign sumSub     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   assign ltSigned   = $signed(a) < $signed(b);
   assign ltUnsigned = a < b;

   always_comb begin
      alu_res = '0;
      cout    = 1'b0;
      ovf     = 1'b0;
      case (alu_ctl)
         ALU_ADD: begin
            {cout, alu_res} = sumAdd;
            ovf = (a[MSB] == b[MSB]) && (sumAdd[MSB] != a[MSB]);
         end
         ALU_ADDU: {cout, alu_res} = sumAdd;
         ALU_SUB: begin
            {cout, alu_res} = sumSub;
            ovf = (a[MSB] != b[MSB]) && (sumSub[MSB] != a[MSB]);
         end
         ALU_SUBU: {cout, alu_res} = sumSub;
         ALU_AND:  alu_res = a & b;
         ALU_OR:   alu_res = a | b;
         ALU_XOR:  alu_res = a ^ b;
         ALU_NOR:  alu_res = ~(a | b);
         ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ltSigned};
         ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ltUnsigned};
         default: begin
            alu_res = '0;
            cout    = 1'b0;
            ovf     = 1'b0;
         end
      endcase
   end

   assign zero       = (alu_res == '0);
   assign immShifted = imm32 << 2;

   add32 #(.WIDTH(WIDTH)) pcAdder (
      .a_i   (pc),
      .b_i   (WIDTH'(4)),
      .sum_o (pc_plus4)
   );

   add32 #(.WIDTH(WIDTH)) branchAdder (
      .a_i   (pc_plus4),
      .b_i   (immShifted),
      .sum_o (branch_tgt)
   );

   // Reset takes priority over an overflow seen in the same cycle.
   always_comb begin
      ovfSticky_d = ovfSticky_q | ovf;
      if (reset) begin
         ovfSticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      ovfSticky_q <= ovfSticky_d;
   end

   assign ovf_sticky = ovfSticky_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results are queued as each
// vector is driven and compared once the combinational outputs settle.
module tb_alu_exec_unit;
   import alu_pkg::*;

   typedef struct {
      string       tag;
      logic [3:0]  ctl;
      logic [31:0] res;
      logic        ovf;
      logic        cout;
      logic [31:0] pc4;
      logic [31:0] tgt;
   } expect_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  alu_op;
   logic [31:0] a, b, pc, imm32;
   logic        cin;
   logic [3:0]  alu_ctl;
   logic [31:0] alu_res, pc_plus4, branch_tgt;
   logic        zero, ovf, cout, ovf_sticky;

   expect_t sbQueue[$];
   int      checks   = 0;
   int      failures = 0;

   alu_exec_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .alu_op     (alu_op),
      .a          (a),
      .b          (b),
      .cin        (cin),
      .pc         (pc),
      .imm32      (imm32),
      .alu_ctl    (alu_ctl),
      .alu_res    (alu_res),
      .zero       (zero),
      .ovf        (ovf),
      .cout       (cout),
      .ovf_sticky (ovf_sticky),
      .pc_plus4   (pc_plus4),
      .branch_tgt (branch_tgt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Pops the oldest expectation and compares every combinational output.
   task automatic compareFront();
      expect_t e;
      if (sbQueue.size() == 0) begin
         checkOutput("sbUnderflow", 32'd1, 32'd0);
         return;
      end
      e = sbQueue.pop_front();
      checkOutput({e.tag, ".ctl"},  32'(alu_ctl),    32'(e.ctl));
      checkOutput({e.tag, ".res"},  alu_res,         e.res);
      checkOutput({e.tag, ".zero"}, 32'(zero),       32'(e.res == 32'd0));
      checkOutput({e.tag, ".ovf"},  32'(ovf),        32'(e.ovf));
      checkOutput({e.tag, ".cout"}, 32'(cout),       32'(e.cout));
      checkOutput({e.tag, ".pc4"},  pc_plus4,        e.pc4);
      checkOutput({e.tag, ".tgt"},  branch_tgt,      e.tgt);
   endtask

   task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [31:0] va,
                                input logic [31:0] vb, input logic vcin, input logic [31:0] vpc,
                                input logic [31:0] vimm, input logic [3:0] eCtl,
                                input logic [31:0] eRes, input logic eOvf, input logic eCout);
      expect_t e;
      @(negedge clk);
      alu_op = op; a = va; b = vb; cin = vcin; pc = vpc; imm32 = vimm;
      e.tag = tag; e.ctl = eCtl; e.res = eRes; e.ovf = eOvf; e.cout = eCout;
      e.pc4 = vpc + 32'd4;
      e.tgt = vpc + 32'd4 + (vimm << 2);
      sbQueue.push_back(e);
      #1;
      compareFront();
   endtask

   task automatic stickyCycle(input string tag, input logic expSticky);
      @(posedge clk);
      #1;
      checkOutput(tag, 32'(ovf_sticky), 32'(expSticky));
   endtask

   // Reference built on 64-bit arithmetic: overflow is a range check on the true signed result.
   task automatic refModel(input logic [5:0] op, input logic [31:0] va, input logic [31:0] vb,
                           input logic vcin, output logic [3:0] ctl, output logic [31:0] res,
                           output logic ovfR, output logic coutR);
      longint sa, sb, sr;
      logic [63:0] wide;
      sa = longint'($signed(va));
      sb = longint'($signed(vb));
      ovfR = 1'b0; coutR = 1'b0; res = '0; ctl = 4'b0010;
      case (op)
         FUNCT_ADD, FUNCT_ADDU: begin
            ctl  = (op == FUNCT_ADD) ? 4'b0010 : 4'b0011;
            wide = {32'd0, va} + {32'd0, vb} + 64'(vcin);
            res  = wide[31:0];
            coutR = wide[32];
            sr = sa + sb + longint'(vcin);
            if (op == FUNCT_ADD) ovfR = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         FUNCT_SUB, FUNCT_SUBU: begin
            ctl   = (op == FUNCT_SUB) ? 4'b0110 : 4'b0111;
            res   = va - vb;
            coutR = (va >= vb);
            sr = sa - sb;
            if (op == FUNCT_SUB) ovfR = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         FUNCT_SLT: begin
            ctl = 4'b1010;
            res = (sa < sb) ? 32'd1 : 32'd0;
         end
         default: begin
            ctl = 4'b1011;
            res = (va < vb) ? 32'd1 : 32'd0;
         end
      endcase
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [5:0]  rOps [4];
      logic [5:0]  rOp;
      logic [31:0] ra, rb;
      logic        rc;
      logic [3:0]  eCtl;
      logic [31:0] eRes;
      logic        eOvf, eCout;

      reset = 1'b1; alu_op = FUNCT_AND; a = '0; b = '0; cin = 1'b0; pc = '0; imm32 = '0;

      // Sticky flag: reset beats a simultaneous overflow, then tracks ovf.
      applyStimulus("ovfInReset", FUNCT_ADD, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h0, 32'h0,
                    4'b0010, 32'h80000000, 1'b1, 1'b0);
      stickyCycle("stickyResetWins", 1'b0);
      reset = 1'b0;
      applyStimulus("andIdle", FUNCT_AND, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0,
                    4'b0000, 32'h0, 1'b0, 1'b0);
      stickyCycle("stickyIdle", 1'b0);
      applyStimulus("addOvf", FUNCT_ADD, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h0, 32'h0,
                    4'b0010, 32'h80000000, 1'b1, 1'b0);
      stickyCycle("stickySet", 1'b1);
      applyStimulus("adduNoOvf", FUNCT_ADDU, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h0, 32'h0,
                    4'b0011, 32'h80000000, 1'b0, 1'b0);
      stickyCycle("stickyHold", 1'b1);
      reset = 1'b1;
      applyStimulus("andReset", FUNCT_AND, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0,
                    4'b0000, 32'h0, 1'b0, 1'b0);
      stickyCycle("stickyCleared", 1'b0);
      reset = 1'b0;
      applyStimulus("subEq", FUNCT_SUB, 32'h5, 32'h5, 1'b0, 32'h0, 32'h0,
                    4'b0110, 32'h0, 1'b0, 1'b1);
      stickyCycle("stickyStays0", 1'b0);

      // Directed ALU and adder vectors.
      applyStimulus("subBorrow", FUNCT_SUB, 32'h0, 32'h1, 1'b0, 32'h0, 32'h0,
                    4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0);
      applyStimulus("sltOvfCmp", FUNCT_SLT, 32'h80000000, 32'h1, 1'b0, 32'h0, 32'h0,
                    4'b1010, 32'h1, 1'b0, 1'b0);
      applyStimulus("sltu", FUNCT_SLTU, 32'h80000000, 32'h1, 1'b0, 32'h0, 32'h0,
                    4'b1011, 32'h0, 1'b0, 1'b0);
      applyStimulus("and", FUNCT_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'h0, 32'h0,
                    4'b0000, 32'hF000F000, 1'b0, 1'b0);
      applyStimulus("or", FUNCT_OR, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0, 32'h0,
                    4'b0001, 32'hFFF0FFF0, 1'b0, 1'b0);
      applyStimulus("xor", FUNCT_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0, 32'h0,
                    4'b1101, 32'h0FF00FF0, 1'b0, 1'b0);
      applyStimulus("nor", FUNCT_NOR, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0, 32'h0,
                    4'b1100, 32'h000F000F, 1'b0, 1'b0);
      applyStimulus("undefOp", 6'b111111, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0, 32'h0,
                    4'b0010, 32'hEFF1EFF0, 1'b0, 1'b1);
      applyStimulus("subuWrap", FUNCT_SUBU, 32'h80000000, 32'h1, 1'b0, 32'h0, 32'h0,
                    4'b0111, 32'h7FFFFFFF, 1'b0, 1'b1);
      applyStimulus("subOvf", FUNCT_SUB, 32'h80000000, 32'h1, 1'b0, 32'h0, 32'h0,
                    4'b0110, 32'h7FFFFFFF, 1'b1, 1'b1);
      applyStimulus("addCin", FUNCT_ADD, 32'h1, 32'h2, 1'b1, 32'h0, 32'h0,
                    4'b0010, 32'h4, 1'b0, 1'b0);
      applyStimulus("adduCinWrap", FUNCT_ADDU, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 32'h0,
                    4'b0011, 32'h0, 1'b0, 1'b1);
      applyStimulus("subIgnoresCin", FUNCT_SUB, 32'hA, 32'h3, 1'b1, 32'h0, 32'h0,
                    4'b0110, 32'h7, 1'b0, 1'b1);
      applyStimulus("branchBack", FUNCT_AND, 32'h0, 32'h0, 1'b0, 32'h00400000, 32'hFFFFFFFF,
                    4'b0000, 32'h0, 1'b0, 1'b0);
      checkOutput("pc4Const", pc_plus4, 32'h00400004);
      checkOutput("tgtConst", branch_tgt, 32'h00400000);
      applyStimulus("pcWrap", FUNCT_AND, 32'h0, 32'h0, 1'b0, 32'hFFFFFFFC, 32'h0,
                    4'b0000, 32'h0, 1'b0, 1'b0);
      checkOutput("pc4WrapConst", pc_plus4, 32'h0);

      // Random arithmetic/compare vectors against the wide-arithmetic reference.
      rOps[0] = FUNCT_ADD; rOps[1] = FUNCT_SUB; rOps[2] = FUNCT_SLT; rOps[3] = FUNCT_SLTU;
      for (int i = 0; i < 24; i++) begin
         rOp = (i % 6 == 5) ? ((i % 12 == 5) ? FUNCT_ADDU : FUNCT_SUBU) : rOps[i % 4];
         ra  = $urandom;
         rb  = (i % 5 == 0) ? ra : $urandom;
         rc  = 1'($urandom_range(0, 1));
         refModel(rOp, ra, rb, rc, eCtl, eRes, eOvf, eCout);
         applyStimulus($sformatf("rand%0d", i), rOp, ra, rb, rc, $urandom, $urandom,
                       eCtl, eRes, eOvf, eCout);
      end

      checkOutput("sbDrained", 32'(sbQueue.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
